// File: rtl/fetch_unit_pkg.sv
// Shared types and default parameters for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int ILEN_DEFAULT  = 32;
  localparam int DEPTH_DEFAULT = 4;

  // Canonical NOP encoding (addi x0, x0, 0), for use as a pipeline bubble.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_buf.sv
// Instruction buffer: a small circular FIFO with flush, holding {inst, pc}.
// The head is read straight out of the storage array, so a pushed entry
// is visible at the output one cycle after the push.
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter  int W     = 64,
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          head_valid,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full       = (cnt == CW'(DEPTH));
  assign head_valid = (cnt != '0);
  assign do_pop     = pop && head_valid && !flush;
  // A push into a full buffer is only legal when the head leaves this cycle.
  assign do_push    = push && (!full || do_pop) && !flush;

  // Storage write port.
  // NOTE: the storage array has no reset; its contents are only observed
  // through head_data, which is forced to zero while the buffer is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_data = head_valid ? mem[rd_ptr] : '0;
  assign count     = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches under a credit rule
// (outstanding requests + buffered instructions never exceed DEPTH), buffers
// in-order responses with their PCs, and discards responses made stale by a
// redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              ILEN     = ILEN_DEFAULT,
  parameter int              DEPTH    = DEPTH_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = ILEN + XLEN;

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] req_pc_q;
  logic [XLEN-1:0] rsp_pc_q;
  logic [CW-1:0]   inflight_q;
  logic [CW-1:0]   drop_cnt_q;
  logic [CW-1:0]   inflight_next;
  logic [CW-1:0]   buf_count;
  logic [CW:0]     credit_used;
  logic            credit_ok;
  logic            issue;
  logic            accept_rsp;
  logic            pop;
  logic [XLEN-1:0] aligned_pc;
  logic [BW-1:0]   head_data;

  assign aligned_pc    = redirect_pc & ~XLEN'(3);
  assign credit_used   = {1'b0, inflight_q} + {1'b0, buf_count};
  assign credit_ok     = (credit_used < (CW+1)'(DEPTH));
  assign issue         = imem_req_valid && imem_req_ready;
  assign accept_rsp    = imem_rsp_valid && (drop_cnt_q == '0);
  assign pop           = out_valid && out_ready;
  assign inflight_next = inflight_q + CW'(issue) - CW'(imem_rsp_valid);
  assign imem_req_addr = req_pc_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and request-valid: one idle cycle after reset, then run.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     imem_req_valid = credit_ok;
      default: state_d = IDLE;
    endcase
  end

  // PC tracking, outstanding-request count and stale-response drop count.
  // A redirect counts everything still in flight after this cycle,
  // including a request issued in the redirect cycle itself, as stale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_pc_q   <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_next;
      if (redirect) begin
        req_pc_q   <= aligned_pc;
        rsp_pc_q   <= aligned_pc;
        drop_cnt_q <= inflight_next;
      end else begin
        if (issue) req_pc_q <= req_pc_q + XLEN'(4);
        if (accept_rsp)          rsp_pc_q   <= rsp_pc_q + XLEN'(4);
        else if (imem_rsp_valid) drop_cnt_q <= drop_cnt_q - CW'(1);
      end
    end
  end

  fetch_buf #(
    .W     (BW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (accept_rsp),
    .push_data  ({imem_rsp_data, rsp_pc_q}),
    .pop        (pop),
    .head_valid (out_valid),
    .head_data  (head_data),
    .count      (buf_count)
  );

  assign out_inst = head_data[BW-1:XLEN];
  assign out_pc   = head_data[XLEN-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level model (request
// queue tagged with a redirect epoch, expected decode stream) checked every
// cycle, plus directed scenarios with literal expectations.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  fetch_unit #(
    .XLEN     (32),
    .ILEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          epoch;
    int          due;
  } req_t;

  req_t        mq[$];      // requests the memory still owes a response for
  logic [31:0] bq[$];      // PCs decode should see, in order
  logic [31:0] pop_pc[$];
  int          pop_cyc[$];
  logic [31:0] next_req;
  int          epoch;
  int          cyc;
  int          mem_lat;
  bit          running;
  int          stale_cnt;
  int          issue_cnt;
  int          first_issue;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] pop_at(input int i);
    return (i < pop_pc.size()) ? pop_pc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int pop_cyc_at(input int i);
    return (i < pop_cyc.size()) ? pop_cyc[i] : -100;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  task automatic compare();
    check("req_valid", imem_req_valid, running && ((mq.size() + bq.size()) < DEPTH));
    check("req_addr", imem_req_addr, next_req);
    check("out_valid", out_valid, bq.size() > 0);
    if (bq.size() > 0) begin
      check("out_pc", out_pc, bq[0]);
      check("out_inst", out_inst, mem_data(bq[0]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, imem_req_valid, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_req_addr"}, imem_req_addr, 0);
    check({tag, "_out_inst"}, out_inst, 0);
    check({tag, "_out_pc"}, out_pc, 0);
  endtask

  task automatic reset_model();
    mq.delete();
    bq.delete();
    next_req       = 32'h0;
    running        = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
  endtask

  task automatic clear_logs();
    pop_pc.delete();
    pop_cyc.delete();
  endtask

  // Called at a falling edge with rst low; releases reset and restarts counts.
  task automatic release_reset();
    rst         = 1'b1;
    cyc         = 0;
    first_issue = -1;
    stale_cnt   = 0;
    clear_logs();
  endtask

  // One clock cycle: memory drives its response, outputs are compared, the
  // model absorbs this cycle's handshakes, then time advances to the next
  // falling edge.
  task automatic cycle();
    req_t r;
    logic iss;
    logic rsp;
    logic pp;
    if (rst && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    compare();
    pp  = out_valid & out_ready;
    rsp = imem_rsp_valid;
    iss = imem_req_valid & imem_req_ready;
    if (pp) begin
      pop_pc.push_back(out_pc);
      pop_cyc.push_back(cyc);
      if (bq.size() > 0) void'(bq.pop_front());
    end
    if (rsp) begin
      r = mq.pop_front();
      if (r.epoch == epoch) begin
        check("buf_room", bq.size() < DEPTH, 1);
        bq.push_back(r.pc);
      end else begin
        stale_cnt++;
      end
    end
    if (iss) begin
      r.pc    = next_req;
      r.data  = mem_data(imem_req_addr);
      r.epoch = epoch;
      r.due   = cyc + mem_lat;
      mq.push_back(r);
      issue_cnt++;
      if (first_issue < 0) first_issue = cyc;
      next_req = next_req + 32'd4;
    end
    if (redirect) begin
      bq.delete();
      epoch++;
      next_req = redirect_pc & ~32'h3;
    end
    @(posedge clk);
    if (rst) running = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    imem_req_ready = 1'b0;
    out_ready      = 1'b1;
    for (int k = 0; k < 40 && (mq.size() + bq.size()) != 0; k++) cycle();
    check("drain", mq.size() + bq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; out_ready = 1'b0; mem_lat = 1;
    epoch = 0; cyc = 0; stale_cnt = 0; issue_cnt = 0; first_issue = -1;
    reset_model();
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    repeat (2) cycle();

    // Streaming from reset with a 1-cycle memory.
    out_ready = 1'b1;
    release_reset();
    repeat (12) cycle();
    check("s1_first_req_cycle", first_issue, 1);
    check("s1_first_pop_cycle", pop_cyc_at(0), 3);
    check("s1_pc0", pop_at(0), 32'h0);
    check("s1_pc1", pop_at(1), 32'h4);
    check("s1_pc2", pop_at(2), 32'h8);
    for (int k = 1; k < 6; k++) check("s1_back_to_back", pop_cyc_at(k) - pop_cyc_at(k - 1), 1);

    // Decode stalled: credits cap issue at DEPTH, one pop reopens one slot.
    out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    cycle();
    redirect = 1'b0; issue_cnt = 0; clear_logs();
    repeat (12) cycle();
    check("s2_issued", issue_cnt, 4);
    check("s2_req_blocked", imem_req_valid, 0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    repeat (6) cycle();
    check("s2_reopen", issue_cnt, 5);
    check("s2_pop_pc", pop_at(0), 32'h40);

    // 3-cycle memory, redirect with three requests in flight.
    mem_lat = 3;
    drain();
    imem_req_ready = 1'b1; stale_cnt = 0;
    repeat (2) cycle();
    redirect = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect = 1'b0; clear_logs();
    repeat (16) cycle();
    check("s3_dropped", stale_cnt, 3);
    check("s3_first_pc", pop_at(0), 32'h100);
    check("s3_second_pc", pop_at(1), 32'h104);

    // Redirect to an unaligned target in the same cycle as an issue.
    mem_lat = 1;
    drain();
    imem_req_ready = 1'b1; stale_cnt = 0;
    redirect = 1'b1; redirect_pc = 32'h203;
    cycle();
    redirect = 1'b0; clear_logs();
    repeat (8) cycle();
    check("s4_dropped", stale_cnt, 1);
    check("s4_first_pc", pop_at(0), 32'h200);

    // Reset mid-operation with two requests outstanding.
    mem_lat = 3;
    drain();
    imem_req_ready = 1'b1; out_ready = 1'b0;
    repeat (2) cycle();
    imem_req_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("mid");
    reset_model();
    @(negedge clk);
    repeat (2) cycle();
    imem_req_ready = 1'b1; out_ready = 1'b1;
    release_reset();
    repeat (8) cycle();
    check("s5_first_req_cycle", first_issue, 1);
    check("s5_restart_pc", pop_at(0), 32'h0);

    // PC wrap at the top of the address space.
    mem_lat = 1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0; clear_logs();
    repeat (8) cycle();
    check("s6_pc_top", pop_at(0), 32'hFFFF_FFFC);
    check("s6_pc_wrap", pop_at(1), 32'h0);
    check("s6_pc_next", pop_at(2), 32'h4);

    // Redirect during the idle cycle right after reset.
    rst = 1'b0;
    reset_model();
    repeat (2) cycle();
    release_reset();
    redirect = 1'b1; redirect_pc = 32'h300;
    cycle();
    redirect = 1'b0;
    repeat (8) cycle();
    check("s7_idle_pc", pop_at(0), 32'h300);
    check("s7_dropped", stale_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, address and PC width.
REQ-002 Parameter ILEN, default 32, instruction width.
REQ-003 Parameter DEPTH, default 4, instruction buffer entries and maximum outstanding requests; power of two, at least 2.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-007 redirect  input  1  flush the unit and restart fetch at redirect_pc.
REQ-008 redirect_pc  input  XLEN  new fetch address; bits [1:0] ignored and treated as 0.
REQ-009 imem_req_valid  output  1  fetch request valid.
REQ-010 imem_req_ready  input  1  memory accepts the request.
REQ-011 imem_req_addr  output  XLEN  fetch address, word-aligned.
REQ-012 imem_rsp_valid  input  1  in-order response valid; cannot be back-pressured.
REQ-013 imem_rsp_data  input  ILEN  fetched instruction.
REQ-014 out_valid  output  1  buffer head valid toward decode.
REQ-015 out_ready  input  1  decode accepts the head.
REQ-016 out_inst  output  ILEN  head instruction.
REQ-017 out_pc  output  XLEN  PC of the head instruction.

Function
REQ-018 The FSM shall have two states, IDLE and RUN: reset enters IDLE, IDLE goes to RUN after one cycle, and RUN is held until reset.
REQ-019 In IDLE, imem_req_valid shall be 0.
REQ-020 In RUN, imem_req_valid shall be 1 when inflight + buf_count < DEPTH (credit rule), with inflight and buf_count as registered values.
REQ-021 A request handshake (valid and ready) shall increment inflight and add 4 to req_pc; imem_req_addr shall equal req_pc.
REQ-022 Each imem_rsp_valid shall decrement inflight; simultaneous issue and response shall leave inflight unchanged.
REQ-023 A response received with drop_cnt = 0 shall be pushed into the buffer together with rsp_pc, and rsp_pc shall then increase by 4.
REQ-024 A response received with drop_cnt > 0 shall be discarded, and drop_cnt shall decrement.
REQ-025 The buffer shall never overflow, which the credit rule guarantees; the bench shall flag an overflow as an error.
REQ-026 A pop (out_valid and out_ready) shall remove the head; push and pop in the same cycle, including when full, shall leave buf_count unchanged.
REQ-027 Push-to-out latency shall be 1 cycle; out_inst and out_pc shall come from registered buffer storage.
REQ-028 On redirect, in the next cycle:
  - buffer empty;
  - req_pc and rsp_pc set to the aligned redirect_pc;
  - drop_cnt set to the inflight value after this cycle's issue and response.
REQ-029 A request issued in the redirect cycle shall be counted as stale; a pop in the redirect cycle shall still complete.
REQ-030 A redirect while drop_cnt > 0 shall reload drop_cnt per REQ-028; new-PC requests may issue while stale responses drain.
REQ-031 A redirect in IDLE shall update req_pc and rsp_pc, with drop_cnt = 0.
REQ-032 A full 1-cycle-latency memory with out_ready held at 1 shall sustain one instruction per cycle.
REQ-033 req_pc and rsp_pc shall wrap modulo 2^XLEN.

Reset
REQ-034 On rst = 0, asynchronously:
  - state = IDLE;
  - req_pc = rsp_pc = RESET_PC;
  - inflight = drop_cnt = buf_count = 0;
  - imem_req_valid = 0, out_valid = 0, imem_req_addr = RESET_PC;
  - out_inst and out_pc = 0.
REQ-035 Reset asserted mid-operation shall abandon all outstanding responses; the memory model shall also be reset.

Structure
REQ-036 The shared package shall hold fetch_state_e (IDLE, RUN), the default XLEN, ILEN and DEPTH, and the NOP encoding 32'h00000013.
REQ-037 A single sub-module, fetch_buf, shall implement the parametrised FIFO (width ILEN+XLEN, DEPTH entries) with flush, push, pop and count.
REQ-038 Counters shall be $clog2(DEPTH)+1 bits wide.

Verification
REQ-039 Reset release, 1-cycle memory, out_ready = 1 -> first request to 0x0 in cycle 1, out_pc sequence 0x0, 0x4, 0x8 on consecutive cycles.
REQ-040 out_ready = 0, DEPTH = 4 -> exactly 4 requests issued, then imem_req_valid = 0; one pop reopens exactly one request.
REQ-041 3-cycle memory, redirect to 0x100 with 3 requests in flight -> 3 responses dropped, first out_pc = 0x100.
REQ-042 Redirect to 0x203 in the same cycle as a request handshake -> stale response dropped, next out_pc = 0x200.
REQ-043 rst pulsed low while 2 requests are outstanding -> all outputs at reset values immediately; after release, fetch restarts at RESET_PC.
REQ-044 redirect_pc = 0xFFFFFFFC, XLEN = 32 -> out_pc sequence 0xFFFFFFFC, 0x00000000.
